// File: rtl/uart_rx_deframer.sv
`timescale 1ns/1ps
// uart_rx_deframer: 16x-oversampled UART receiver (7/8 data bits, optional parity, one stop
// bit) feeding a single-entry holding register with parity, framing and overflow status.
module uart_rx_deframer #(
    parameter bit MAJORITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_data_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    localparam logic [3:0] DEC_IDX = MAJORITY_EN ? 4'd9 : 4'd8;

    state_t     state, state_nxt;
    logic       rx_meta, rx_s;
    logic [3:0] os_cnt, tick_idx;
    logic       s7, s8;
    logic       dec_tick, wrap_tick, bit_val;
    logic [3:0] bit_cnt, nbits;
    logic [7:0] shreg;
    logic       par_bit;
    logic       cfg_bit8, cfg_par_en, cfg_odd;
    logic       start_det, shift_en, par_ld, stop_dec;
    logic [7:0] data_byte;
    logic       frame_perr;
    logic       done_q, done_perr, done_ferr;
    logic [7:0] done_byte;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // os_cnt holds the index of the most recent tick; the start-detect tick is index 0.
    assign tick_idx  = os_cnt + 4'd1;
    assign dec_tick  = baud_clock && (tick_idx == DEC_IDX);
    assign wrap_tick = baud_clock && (tick_idx == 4'd0);
    assign bit_val   = MAJORITY_EN ? ((s7 & s8) | (s7 & rx_s) | (s8 & rx_s)) : rx_s;
    assign nbits     = cfg_bit8 ? 4'd8 : 4'd7;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_ld    = 1'b0;
        stop_dec  = 1'b0;
        case (state)
            S_IDLE: begin
                if (baud_clock && !rx_s) begin
                    state_nxt = S_START;
                    start_det = 1'b1;
                end
            end
            S_START: begin
                if (dec_tick && bit_val) state_nxt = S_IDLE;
                else if (wrap_tick)      state_nxt = S_DATA;
            end
            S_DATA: begin
                shift_en = dec_tick;
                if (wrap_tick && (bit_cnt == nbits))
                    state_nxt = cfg_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                par_ld = dec_tick;
                if (wrap_tick) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (dec_tick) begin
                    stop_dec  = 1'b1;
                    state_nxt = bit_val ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (baud_clock && rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            os_cnt     <= 4'd0;
            s7         <= 1'b1;
            s8         <= 1'b1;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            cfg_bit8   <= 1'b1;
            cfg_par_en <= 1'b0;
            cfg_odd    <= 1'b0;
        end else begin
            if (start_det) begin
                os_cnt     <= 4'd0;
                bit_cnt    <= 4'd0;
                cfg_bit8   <= bit8;
                cfg_par_en <= parity_en;
                cfg_odd    <= odd_n_even;
            end else if (baud_clock && state != S_IDLE) begin
                os_cnt <= tick_idx;
            end
            if (baud_clock && tick_idx == 4'd7) s7 <= rx_s;
            if (baud_clock && tick_idx == 4'd8) s8 <= rx_s;
            if (shift_en) begin
                shreg   <= {bit_val, shreg[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (par_ld) par_bit <= bit_val;
        end
    end

    // Seven shifts leave the first bit in shreg[1], so realign 7-bit frames.
    assign data_byte  = cfg_bit8 ? shreg : {1'b0, shreg[7:1]};
    assign frame_perr = cfg_par_en & ((^data_byte ^ par_bit) != cfg_odd);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            done_q    <= 1'b0;
            done_byte <= 8'h00;
            done_perr <= 1'b0;
            done_ferr <= 1'b0;
        end else begin
            done_q <= stop_dec;
            if (stop_dec) begin
                done_byte <= data_byte;
                done_perr <= frame_perr;
                done_ferr <= ~bit_val;
            end
        end
    end

    // Handshake: rx_data_ready is the valid flag of the holding register; a one-cycle
    // read_rx_byte consumes it. A completing frame loads only if the register is empty or
    // is being read in that same cycle; otherwise it is dropped and overflow latches.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rx_byte       <= 8'h00;
            rx_data_ready <= 1'b0;
            parity_err    <= 1'b0;
            framing_err   <= 1'b0;
            overflow      <= 1'b0;
        end else if (done_q) begin
            if (!rx_data_ready || read_rx_byte) begin
                rx_byte       <= done_byte;
                parity_err    <= done_perr;
                framing_err   <= done_ferr;
                rx_data_ready <= 1'b1;
                if (read_rx_byte) overflow <= 1'b0;
            end else begin
                overflow <= 1'b1;
            end
        end else if (read_rx_byte && rx_data_ready) begin
            rx_data_ready <= 1'b0;
            overflow      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
`timescale 1ns/1ps
// Bench for uart_rx_deframer: serialises frames at 16 ticks per bit (one tick every 4 clk)
// and checks the holding register against a queue of expected {framing, parity, byte}.
module tb_uart_rx_deframer;

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       baud_clock;
    logic       rx = 1'b1;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       read_rx_byte = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_data_ready, parity_err, framing_err, overflow;
    logic [2:0] dbg_state;

    logic [1:0] div = 2'd0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];

    uart_rx_deframer dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .baud_clock    (baud_clock),
        .rx            (rx),
        .bit8          (bit8),
        .parity_en     (parity_en),
        .odd_n_even    (odd_n_even),
        .read_rx_byte  (read_rx_byte),
        .rx_byte       (rx_byte),
        .rx_data_ready (rx_data_ready),
        .parity_err    (parity_err),
        .framing_err   (framing_err),
        .overflow      (overflow),
        .dbg_state     (dbg_state)
    );

    // Clock / reset / tick generation
    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign baud_clock = (div == 2'd3);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do begin
                @(posedge clk);
                #1;
            end while (div != 2'd0);
        end
    endtask

    task automatic read_pulse();
        read_rx_byte = 1'b1;
        @(posedge clk);
        #1;
        read_rx_byte = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop_bit,
                              input logic read_at_done, input logic toggle_cfg,
                              input logic push_exp);
        logic       c8, cp, co, perr;
        logic [7:0] eb;
        int         nb;
        c8   = bit8;
        cp   = parity_en;
        co   = odd_n_even;
        nb   = c8 ? 8 : 7;
        eb   = c8 ? data : {1'b0, data[6:0]};
        perr = cp && ((^eb ^ pbit) != co);
        if (push_exp) exp_q.push_back({~stop_bit, perr, eb});
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nb; i++) begin
            rx = data[i];
            if (toggle_cfg && i == 3) begin
                bit8       = ~bit8;
                parity_en  = ~parity_en;
                odd_n_even = ~odd_n_even;
            end
            wait_ticks(16);
        end
        if (cp) begin
            rx = pbit;
            wait_ticks(16);
        end
        rx = stop_bit;
        wait_ticks(10);
        if (read_at_done) read_pulse();
        wait_ticks(6);
        bit8       = c8;
        parity_en  = cp;
        odd_n_even = co;
    endtask

    // Tests
    task automatic test_reset();
        aresetn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({rx_byte, rx_data_ready, parity_err, framing_err, overflow} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got byte=%h rdy=%b pe=%b fe=%b ov=%b want all 0",
                     rx_byte, rx_data_ready, parity_err, framing_err, overflow);
        end
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        aresetn = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_8n1();
        logic [9:0] e;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL 8n1_frame: queue empty");
        end else begin
            e = exp_q.pop_front();
            if ({framing_err, parity_err, rx_byte} !== e || rx_data_ready !== 1'b1 || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL 8n1_frame: got %h rdy=%b ov=%b want %h rdy=1 ov=0",
                         {framing_err, parity_err, rx_byte}, rx_data_ready, overflow, e);
            end
        end
        read_pulse();
        n_cmp++;
        if (rx_data_ready !== 1'b0 || rx_byte !== 8'hA5) begin
            n_err++;
            $display("FAIL 8n1_read: got rdy=%b byte=%h want rdy=0 byte=a5", rx_data_ready, rx_byte);
        end
    endtask

    task automatic test_parity();
        logic [9:0] e;
        bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'h3C, k[0], 1'b1, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL parity_%0d: queue empty", k);
            end else begin
                e = exp_q.pop_front();
                if ({framing_err, parity_err, rx_byte} !== e || rx_data_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL parity_%0d: got %h rdy=%b want %h rdy=1",
                             k, {framing_err, parity_err, rx_byte}, rx_data_ready, e);
                end
            end
            read_pulse();
        end
    endtask

    task automatic test_7bit();
        logic [9:0] e;
        logic [7:0] d;
        logic       pb;
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
        for (int k = 0; k < 2; k++) begin
            d  = (k == 0) ? 8'h41 : 8'hC1;
            pb = (k == 0);
            send_frame(d, pb, 1'b1, 1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL 7bit_%0d: queue empty", k);
            end else begin
                e = exp_q.pop_front();
                if ({framing_err, parity_err, rx_byte} !== e || rx_data_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL 7bit_%0d: got %h rdy=%b want %h rdy=1",
                             k, {framing_err, parity_err, rx_byte}, rx_data_ready, e);
                end
            end
            read_pulse();
        end
    endtask

    task automatic test_false_start();
        rx = 1'b0;
        wait_ticks(5);
        rx = 1'b1;
        wait_ticks(40);
        n_cmp++;
        if ({rx_byte, rx_data_ready, parity_err, framing_err, overflow} !== {8'h41, 4'b0100}
            || dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL false_start: got byte=%h rdy=%b pe=%b fe=%b ov=%b st=%0d want 41 0 1 0 0 st=0",
                     rx_byte, rx_data_ready, parity_err, framing_err, overflow, dbg_state);
        end
    endtask

    task automatic test_framing();
        logic [9:0] e;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL framing: queue empty");
        end else begin
            e = exp_q.pop_front();
            if ({framing_err, parity_err, rx_byte} !== e || rx_data_ready !== 1'b1) begin
                n_err++;
                $display("FAIL framing: got %h rdy=%b want %h rdy=1",
                         {framing_err, parity_err, rx_byte}, rx_data_ready, e);
            end
        end
        wait_ticks(40);
        rx = 1'b1;
        wait_ticks(40);
        n_cmp++;
        if (rx_data_ready !== 1'b1 || overflow !== 1'b0 || rx_byte !== 8'h55 || framing_err !== 1'b1) begin
            n_err++;
            $display("FAIL break_no_retrigger: got rdy=%b ov=%b byte=%h fe=%b want 1 0 55 1",
                     rx_data_ready, overflow, rx_byte, framing_err);
        end
        read_pulse();
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL overflow_keep: queue empty");
        end else begin
            e = exp_q.pop_front();
            if ({framing_err, parity_err, rx_byte} !== e || rx_data_ready !== 1'b1 || overflow !== 1'b1) begin
                n_err++;
                $display("FAIL overflow_keep: got %h rdy=%b ov=%b want %h rdy=1 ov=1",
                         {framing_err, parity_err, rx_byte}, rx_data_ready, overflow, e);
            end
        end
        read_pulse();
        n_cmp++;
        if (rx_data_ready !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clear: got rdy=%b ov=%b want 0 0", rx_data_ready, overflow);
        end
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL b2b_first: queue empty");
        end else begin
            e = exp_q.pop_front();
            if ({framing_err, parity_err, rx_byte} !== e || rx_data_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_first: got %h rdy=%b want %h rdy=1",
                         {framing_err, parity_err, rx_byte}, rx_data_ready, e);
            end
        end
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL read_at_done: queue empty");
        end else begin
            e = exp_q.pop_front();
            if ({framing_err, parity_err, rx_byte} !== e || rx_data_ready !== 1'b1 || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL read_at_done: got %h rdy=%b ov=%b want %h rdy=1 ov=0",
                         {framing_err, parity_err, rx_byte}, rx_data_ready, overflow, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        logic [7:0] d;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        d  = 8'h9E;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = d[4];
        wait_ticks(8);
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({rx_byte, rx_data_ready, parity_err, framing_err, overflow} !== 12'h000 || dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid: got byte=%h rdy=%b pe=%b fe=%b ov=%b st=%0d want all 0",
                     rx_byte, rx_data_ready, parity_err, framing_err, overflow, dbg_state);
        end
        rx = 1'b1;
        wait_ticks(2);
        aresetn = 1'b1;
        wait_ticks(20);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL after_reset: queue empty");
        end else begin
            e = exp_q.pop_front();
            if ({framing_err, parity_err, rx_byte} !== e || rx_data_ready !== 1'b1 || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL after_reset: got %h rdy=%b ov=%b want %h rdy=1 ov=0",
                         {framing_err, parity_err, rx_byte}, rx_data_ready, overflow, e);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d queued entries want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7bit();
        test_false_start();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Asynchronous serial receiver that consumes the 16x `baud_clock` enable pulse produced by the UART clock generator. It oversamples the `rx` line, validates start bits, deframes 7/8 data bits with optional parity and one stop bit, and presents the byte in a holding register with ready, parity, framing and overflow status. It is the receive-side counterpart of the transmit path in the CoreUART core and runs entirely on the system clock.

## Interface
- `MAJORITY_EN`, default 1: 1 = each bit is decided by a 2-of-3 vote of samples at ticks 7, 8 and 9; 0 = each bit is the single sample at tick 8.
- `clk` in 1: system clock.
- `aresetn` in 1: reset, asynchronous, active-low; clock `clk`.
- `baud_clock` in 1: one-`clk`-wide 16x oversample enable ("tick"). It may be high every cycle.
- `rx` in 1: asynchronous serial input; idles high.
- `bit8` in 1: 1 = 8 data bits; 0 = 7 data bits.
- `parity_en` in 1: 1 = a parity bit follows the data bits.
- `odd_n_even` in 1: 1 = odd parity; 0 = even parity.
- `read_rx_byte` in 1: one-cycle pulse that consumes the holding register.
- `rx_byte` out 8: received data, LSB first on the line. Bit 7 is 0 in 7-bit mode.
- `rx_data_ready` out 1: holding register is valid.
- `parity_err` out 1: parity status of the held byte.
- `framing_err` out 1: stop bit of the held byte sampled 0.
- `overflow` out 1: sticky flag; a frame completed while `rx_data_ready` was 1.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- A 4-bit tick counter `os_cnt` advances only on `baud_clock` and wraps 15→0. One bit time is 16 ticks.
- States:
  - IDLE: on a tick with `rx_s`=0, go to START and set `os_cnt`=0. Latch `bit8`, `parity_en` and `odd_n_even` at this point; mid-frame changes to these inputs are ignored.
  - START: decide at tick 9 (MAJORITY_EN=1) or tick 8. If the decided value is 1, this is a false start: go to IDLE with no status change. Otherwise go to DATA when `os_cnt` wraps.
  - DATA: decide each bit as above and shift it in LSB-first. After 7 or 8 bits go to PARITY if parity is enabled, else to STOP.
  - PARITY: decide the parity bit. Error if (XOR of data bits ^ parity bit) != `odd_n_even`.
  - STOP: at the decision tick, complete the frame and go to IDLE if stop=1, or to WAIT_HIGH if stop=0.
  - WAIT_HIGH: remain until a tick with `rx_s`=1, then go to IDLE. This prevents a break condition from retriggering reception.
- Frame completion with `rx_data_ready`=0, or with `read_rx_byte` in the same cycle:
  - load `rx_byte`, `parity_err` and `framing_err`;
  - set `rx_data_ready`=1.
- Frame completion with `rx_data_ready`=1 and no read in that cycle:
  - the holding register and error flags are kept;
  - set `overflow`=1;
  - the new frame is dropped.
- `read_rx_byte` with no simultaneous completion: clears `rx_data_ready` and `overflow`. `rx_byte`, `parity_err` and `framing_err` hold their values until the next load.
- `read_rx_byte` while `rx_data_ready`=0: no effect.
- Reset mid-frame: the state machine goes to IDLE immediately and the partial frame is discarded.

## Timing
- Reset values:
  - `rx_byte`=0x00;
  - `rx_data_ready`, `parity_err`, `framing_err`, `overflow` = 0;
  - state IDLE, `os_cnt`=0, synchronizer=1.
- Input latency: 2 `clk` from an `rx` edge to `rx_s`. Start detection occurs on the first tick after that.
- Each bit decision is registered on the `clk` edge of its decision tick.
- All status outputs update 1 `clk` after the STOP decision tick.
- Total frame latency is 16·(1+N+P)+9 ticks (MAJORITY_EN=1) or 16·(1+N+P)+8 ticks (MAJORITY_EN=0) after the start-detect tick. N = 7 or 8 data bits; P = 0 or 1 parity bit.
- Back-to-back frames are supported: IDLE is re-entered in mid-stop-bit, so the next start edge is detected with no lost ticks.

## Test plan
- 8N1, ticks every 4 `clk`, send 0xA5 → `rx_byte`=0xA5, `rx_data_ready`=1, all error flags 0. A `read_rx_byte` pulse → `rx_data_ready`=0 on the next cycle.
- 8E1, send 0x3C with parity bit 0 → `parity_err`=0. Repeat with parity bit 1 → `parity_err`=1 and `rx_byte`=0x3C.
- 7O1 (`bit8`=0), send 0x41 with parity 1 → `rx_byte`=0x41, `parity_err`=0. Toggle `bit8` mid-frame → result unchanged.
- Pull `rx` low for 5 ticks, then high → no frame received, all outputs unchanged. Also: stop bit 0 on 0x55 → `framing_err`=1, `rx_byte`=0x55; hold `rx` low 40 ticks → no second frame.
- Send 0x11 then 0x22 back-to-back with no read → `rx_byte`=0x11, `overflow`=1. A read clears `overflow` and `rx_data_ready`. Read coincident with the completion of 0x22 → 0x22 loaded, no overflow.
- Assert `aresetn` during data bit 4 of a frame → all outputs return to reset values. The next clean frame 0xC3 is received correctly.
